// File: rtl/jt49_wrseq_pkg.sv
// Shared op codes and FSM state encoding for the jt49 write sequencer.
package jt49_wrseq_pkg;

    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_WAIT = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WR   = 3'd1,
        ST_RD   = 3'd2,
        ST_WAIT = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

endpackage

// File: rtl/jt49_wrseq_if.sv
// Command stream and PSG CPU-side bus of the jt49 write sequencer.
interface jt49_wrseq_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_data;

    logic [3:0] bus_addr;
    logic       bus_cs_n;
    logic       bus_wr_n;
    logic [7:0] bus_din;
    logic [7:0] psg_dout;

    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    // master: command producer and PSG side; slave: the sequencer itself
    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, psg_dout,
        input  cmd_ready, bus_addr, bus_cs_n, bus_wr_n, bus_din,
               rd_data, rd_valid, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, psg_dout,
        output cmd_ready, bus_addr, bus_cs_n, bus_wr_n, bus_din,
               rd_data, rd_valid, busy
    );

endinterface

// File: rtl/jt49_wrseq.sv
// Replays write/read/wait commands onto the jt49 CPU port with timed strobes
// and a mandatory idle gap after every access.
module jt49_wrseq
    import jt49_wrseq_pkg::*;
#(
    parameter int WR_CYCLES  = 2,
    parameter int RD_LAT     = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic         tick,
    jt49_wrseq_if.slave  bus
);

    localparam logic [7:0] WR_LOAD  = 8'(WR_CYCLES  - 1);
    localparam logic [7:0] RD_LOAD  = 8'(RD_LAT     - 1);
    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    state_t     state;
    logic [7:0] cnt;

    assign bus.cmd_ready = (state == ST_IDLE) & ~rst;
    assign bus.busy      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            bus.bus_addr <= 4'd0;
            bus.bus_din  <= 8'd0;
            bus.bus_cs_n <= 1'b1;
            bus.bus_wr_n <= 1'b1;
            bus.rd_data  <= 8'd0;
            bus.rd_valid <= 1'b0;
        end else begin
            // rd_valid is a single-clk pulse regardless of cen
            bus.rd_valid <= 1'b0;
            if (cen) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.cmd_valid) begin
                            case (bus.cmd_op)
                                OP_WR: begin
                                    bus.bus_addr <= bus.cmd_addr;
                                    bus.bus_din  <= bus.cmd_data;
                                    bus.bus_cs_n <= 1'b0;
                                    bus.bus_wr_n <= 1'b0;
                                    cnt          <= WR_LOAD;
                                    state        <= ST_WR;
                                end
                                OP_RD: begin
                                    bus.bus_addr <= bus.cmd_addr;
                                    bus.bus_cs_n <= 1'b0;
                                    bus.bus_wr_n <= 1'b1;
                                    cnt          <= RD_LOAD;
                                    state        <= ST_RD;
                                end
                                OP_WAIT: begin
                                    if (bus.cmd_data != 8'd0) begin
                                        cnt   <= bus.cmd_data;
                                        state <= ST_WAIT;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_WR: begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            bus.bus_cs_n <= 1'b1;
                            bus.bus_wr_n <= 1'b1;
                            cnt          <= GAP_LOAD;
                            state        <= ST_GAP;
                        end
                    end
                    ST_RD: begin
                        if (cnt != 8'd0) begin
                            cnt <= cnt - 8'd1;
                        end else begin
                            bus.rd_data  <= bus.psg_dout;
                            bus.rd_valid <= 1'b1;
                            bus.bus_cs_n <= 1'b1;
                            cnt          <= GAP_LOAD;
                            state        <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        if (cnt != 8'd0) cnt <= cnt - 8'd1;
                        else             state <= ST_IDLE;
                    end
                    ST_WAIT: begin
                        // the last tick returns straight to IDLE, no gap needed
                        if (tick) begin
                            cnt <= cnt - 8'd1;
                            if (cnt == 8'd1) state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jt49_wrseq.sv
// Directed bench for jt49_wrseq with a small jt49 register-file model.
module tb_jt49_wrseq;
    import jt49_wrseq_pkg::*;

    localparam int RD_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b1;
    logic tick = 1'b0;

    int passed = 0;
    int total  = 0;

    jt49_wrseq_if bus_if();

    jt49_wrseq #(.WR_CYCLES(2), .RD_LAT(RD_LAT), .GAP_CYCLES(1)) dut (
        .clk  (clk),
        .rst  (rst),
        .cen  (cen),
        .tick (tick),
        .bus  (bus_if.slave)
    );

    always #5 clk = ~clk;

    // jt49 register model: level write while cs_n/wr_n low, masked storage
    logic [7:0] regs [16];
    logic       prev_wr_n = 1'b1;
    int         eg_restarts = 0;
    int         hi_run = 0;
    int         last_gap = 0;

    function automatic logic [7:0] psg_mask(input logic [3:0] a, input logic [7:0] d);
        case (a)
            4'd1, 4'd3, 4'd5, 4'd13:  psg_mask = d & 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:  psg_mask = d & 8'h1F;
            default:                  psg_mask = d;
        endcase
    endfunction

    initial for (int i = 0; i < 16; i++) regs[i] = 8'd0;

    assign bus_if.psg_dout = regs[bus_if.bus_addr];

    always @(posedge clk) begin
        if (!bus_if.bus_cs_n && !bus_if.bus_wr_n) begin
            regs[bus_if.bus_addr] <= psg_mask(bus_if.bus_addr, bus_if.bus_din);
            if (prev_wr_n && bus_if.bus_addr == 4'd13) eg_restarts <= eg_restarts + 1;
        end
        if (bus_if.bus_wr_n) begin
            hi_run <= hi_run + 1;
        end else begin
            if (prev_wr_n) last_gap <= hi_run;
            hi_run <= 0;
        end
        prev_wr_n <= bus_if.bus_wr_n;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [7:0] d);
        int   n;
        logic acc;
        bus_if.cmd_op    = op;
        bus_if.cmd_addr  = a;
        bus_if.cmd_data  = d;
        bus_if.cmd_valid = 1'b1;
        n = 0;
        do begin
            acc = bus_if.cmd_ready && cen;
            step();
            n++;
        end while (!acc && n < 200);
        bus_if.cmd_valid = 1'b0;
        if (!acc) begin
            total++;
            $display("FAIL issue_timeout op=%0d accepted=%0b required=1", op, acc);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus_if.busy && n < 200) begin
            step();
            n++;
        end
        total++;
        if (bus_if.busy) $display("FAIL wait_idle_timeout busy=%0b required=0", bus_if.busy);
        else passed++;
    endtask

    task automatic test_reset();
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_op    = OP_WR;
        bus_if.cmd_addr  = 4'd0;
        bus_if.cmd_data  = 8'd0;
        repeat (3) step();
        total++; if ({bus_if.bus_cs_n, bus_if.bus_wr_n} !== 2'b11)
            $display("FAIL rst_strobes got=%b required=11", {bus_if.bus_cs_n, bus_if.bus_wr_n}); else passed++;
        total++; if ({bus_if.bus_addr, bus_if.bus_din} !== 12'h000)
            $display("FAIL rst_addr_din got=%h required=000", {bus_if.bus_addr, bus_if.bus_din}); else passed++;
        total++; if ({bus_if.rd_data, bus_if.rd_valid, bus_if.busy} !== 10'd0)
            $display("FAIL rst_rd_busy got=%h required=000", {bus_if.rd_data, bus_if.rd_valid, bus_if.busy}); else passed++;
        total++; if (bus_if.cmd_ready !== 1'b0)
            $display("FAIL rst_ready_in_reset got=%b required=0", bus_if.cmd_ready); else passed++;
        rst = 1'b0;
        #1;
        total++; if (bus_if.cmd_ready !== 1'b1)
            $display("FAIL rst_ready_after got=%b required=1", bus_if.cmd_ready); else passed++;
    endtask

    task automatic test_single_write();
        issue(OP_WR, 4'd7, 8'h38);
        for (int i = 0; i < 2; i++) begin
            total++; if ({bus_if.bus_cs_n, bus_if.bus_wr_n, bus_if.bus_addr, bus_if.bus_din} !== {2'b00, 4'd7, 8'h38})
                $display("FAIL wr_strobe_%0d got=%b_%h_%h required=00_7_38", i,
                         {bus_if.bus_cs_n, bus_if.bus_wr_n}, bus_if.bus_addr, bus_if.bus_din); else passed++;
            step();
        end
        total++; if ({bus_if.bus_cs_n, bus_if.bus_wr_n, bus_if.cmd_ready} !== 3'b110)
            $display("FAIL wr_release got=%b required=110", {bus_if.bus_cs_n, bus_if.bus_wr_n, bus_if.cmd_ready}); else passed++;
        step();
        total++; if ({bus_if.cmd_ready, bus_if.busy} !== 2'b10)
            $display("FAIL wr_ready_back got=%b required=10", {bus_if.cmd_ready, bus_if.busy}); else passed++;
        total++; if (regs[7] !== 8'h38)
            $display("FAIL wr_model_reg7 got=%h required=38", regs[7]); else passed++;
    endtask

    task automatic test_back_to_back();
        int r0 = eg_restarts;
        issue(OP_WR, 4'd13, 8'h0E);
        issue(OP_WR, 4'd13, 8'h0A);
        wait_idle();
        step();
        total++; if (eg_restarts - r0 !== 2)
            $display("FAIL b2b_restarts got=%0d required=2", eg_restarts - r0); else passed++;
        total++; if (last_gap < 1)
            $display("FAIL b2b_wr_gap got=%0d required>=1", last_gap); else passed++;
        total++; if (regs[13] !== 8'h0A)
            $display("FAIL b2b_reg13 got=%h required=0a", regs[13]); else passed++;
    endtask

    task automatic test_read();
        int   first = -1;
        int   pulses = 0;
        logic wr_low = 1'b0;
        logic [7:0] data_at_pulse = 8'h00;
        issue(OP_WR, 4'd1, 8'h5A);
        wait_idle();
        issue(OP_RD, 4'd1, 8'h00);
        for (int i = 0; i < 6; i++) begin
            if (bus_if.rd_valid) begin
                pulses++;
                if (first < 0) first = i;
                data_at_pulse = bus_if.rd_data;
            end
            if (!bus_if.bus_wr_n) wr_low = 1'b1;
            step();
        end
        total++; if (pulses !== 1) $display("FAIL rd_pulses got=%0d required=1", pulses); else passed++;
        total++; if (first !== RD_LAT) $display("FAIL rd_latency got=%0d required=%0d", first, RD_LAT); else passed++;
        total++; if (data_at_pulse !== 8'h0A) $display("FAIL rd_data got=%h required=0a", data_at_pulse); else passed++;
        total++; if (wr_low !== 1'b0) $display("FAIL rd_wr_n_low got=%b required=0", wr_low); else passed++;
    endtask

    task automatic test_wait();
        logic cs_low = 1'b0;
        tick = 1'b1;
        issue(OP_WAIT, 4'd0, 8'd3);
        tick = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            repeat (9) step();
            total++; if (bus_if.busy !== 1'b1)
                $display("FAIL wait_busy_before_tick%0d got=%b required=1", k, bus_if.busy); else passed++;
            tick = 1'b1;
            step();
            tick = 1'b0;
        end
        total++; if (bus_if.busy !== 1'b0)
            $display("FAIL wait_done got=%b required=0", bus_if.busy); else passed++;
        issue(OP_WAIT, 4'd0, 8'd0);
        for (int i = 0; i < 3; i++) begin
            if (!bus_if.bus_cs_n || bus_if.busy) cs_low = 1'b1;
            step();
        end
        issue(OP_RSV, 4'd3, 8'd5);
        if (!bus_if.bus_cs_n || bus_if.busy) cs_low = 1'b1;
        total++; if (cs_low !== 1'b0)
            $display("FAIL wait_zero_activity got=%b required=0", cs_low); else passed++;
        total++; if (bus_if.cmd_ready !== 1'b1)
            $display("FAIL wait_zero_ready got=%b required=1", bus_if.cmd_ready); else passed++;
    endtask

    task automatic test_cen_toggle();
        int low_clks = 0;
        bus_if.cmd_op    = OP_WR;
        bus_if.cmd_addr  = 4'd2;
        bus_if.cmd_data  = 8'h11;
        bus_if.cmd_valid = 1'b1;
        cen = 1'b0;
        step();
        total++; if (bus_if.busy !== 1'b0)
            $display("FAIL cen_no_accept got=%b required=0", bus_if.busy); else passed++;
        cen = 1'b1;
        step();
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!bus_if.bus_cs_n && !bus_if.bus_wr_n) low_clks++;
            cen = ~cen;
            step();
        end
        cen = 1'b1;
        total++; if (low_clks !== 4)
            $display("FAIL cen_strobe_clks got=%0d required=4", low_clks); else passed++;
        wait_idle();
        total++; if (regs[2] !== 8'h11)
            $display("FAIL cen_model_reg2 got=%h required=11", regs[2]); else passed++;
    endtask

    task automatic test_reset_mid();
        issue(OP_WR, 4'd5, 8'h0C);
        step();
        #1 rst = 1'b1;
        #1;
        total++; if ({bus_if.bus_cs_n, bus_if.bus_wr_n, bus_if.busy} !== 3'b110)
            $display("FAIL rstmid_async got=%b required=110", {bus_if.bus_cs_n, bus_if.bus_wr_n, bus_if.busy}); else passed++;
        step();
        rst = 1'b0;
        #1;
        total++; if (bus_if.cmd_ready !== 1'b1)
            $display("FAIL rstmid_ready got=%b required=1", bus_if.cmd_ready); else passed++;
        issue(OP_WR, 4'd5, 8'h07);
        wait_idle();
        step();
        total++; if (regs[5] !== 8'h07)
            $display("FAIL rstmid_next_write got=%h required=07", regs[5]); else passed++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read();
        test_wait();
        test_cen_toggle();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
